// File: rtl/letc_core_pkg.sv
// Shared types for the LETC core cache path: request payload, access size and
// the cache arbiter state encoding.
package letc_core_pkg;

  localparam int LETC_CORE_CACHE_NUM_REQ = 2;
  localparam int LETC_CORE_ADDR_W        = 32;
  localparam int LETC_CORE_DATA_W        = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } cache_size_e;

  typedef struct packed {
    logic [LETC_CORE_ADDR_W-1:0] addr;
    logic                        wen;
    logic [LETC_CORE_DATA_W-1:0] wdata;
    cache_size_e                 size;
  } cache_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/letc_core_cache_arbiter_if.sv
// Stage-side and cache-side signals of the shared core cache port. Names are
// from the arbiter's point of view; the slave modport is the arbiter.
interface letc_core_cache_arbiter_if #(
  parameter int NUM_REQ = letc_core_pkg::LETC_CORE_CACHE_NUM_REQ,
  parameter int DATA_W  = letc_core_pkg::LETC_CORE_DATA_W
);
  import letc_core_pkg::*;

  // Handshakes: a transfer happens in a cycle where valid and ready are both 1
  // at the rising clock edge; the source holds valid and payload until then.
  logic [NUM_REQ-1:0]     i_req_valid;
  logic [NUM_REQ-1:0]     o_req_ready;
  cache_req_t [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0]     o_rsp_valid;
  logic [DATA_W-1:0]      o_rsp_rdata;
  logic                   o_cache_valid;
  logic                   i_cache_ready;
  cache_req_t             o_cache_req;
  logic                   i_cache_rsp_valid;
  logic [DATA_W-1:0]      i_cache_rsp_rdata;

  modport slave (
    input  i_req_valid, i_req, i_cache_ready, i_cache_rsp_valid, i_cache_rsp_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_cache_valid, o_cache_req
  );

  modport master (
    output i_req_valid, i_req, i_cache_ready, i_cache_rsp_valid, i_cache_rsp_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_cache_valid, o_cache_req
  );

endinterface

// File: rtl/letc_core_rr_arbiter.sv
// Winner pick over the request vector. Round-robin with a pointer register by
// default; LETC_CORE_CACHE_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module letc_core_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant_onehot,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic found;

`ifdef LETC_CORE_CACHE_ARB_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = ^{i_clk, i_rst, i_advance};

  always_comb begin
    o_grant_onehot = '0;
    o_grant_idx    = '0;
    found          = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && i_req[k]) begin
        found             = 1'b1;
        o_grant_onehot[k] = 1'b1;
        o_grant_idx       = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  // Search begins at the pointer and wraps, so the last winner goes to the back.
  always_comb begin
    o_grant_onehot = '0;
    o_grant_idx    = '0;
    found          = 1'b0;
    cand           = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + 32'(k)) % 32'(NUM_REQ));
      if (!found && i_req[cand]) begin
        found                = 1'b1;
        o_grant_onehot[cand] = 1'b1;
        o_grant_idx          = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (i_advance) begin
      ptr_d = (o_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/letc_core_cache_arbiter.sv
// Shares one core cache port between NUM_REQ pipeline stages, one transaction
// in flight. Define LETC_CORE_CACHE_ARB_FIXED_PRIO_EN for fixed priority.
module letc_core_cache_arbiter
  import letc_core_pkg::*;
#(
  parameter  int NUM_REQ = LETC_CORE_CACHE_NUM_REQ,
  parameter  int ADDR_W  = LETC_CORE_ADDR_W,
  parameter  int DATA_W  = LETC_CORE_DATA_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  letc_core_cache_arbiter_if.slave bus,
  output logic                     o_busy,
  output logic [IDX_W-1:0]         o_grant_idx,
  output arb_state_e               o_state
);

  // The payload struct has fixed widths, so parameters must agree with it.
  if (ADDR_W != LETC_CORE_ADDR_W || DATA_W != LETC_CORE_DATA_W) begin : g_width_check
    $error("letc_core_cache_arbiter: ADDR_W/DATA_W must match letc_core_pkg");
  end

  arb_state_e         state_q, state_d;
  cache_req_t         payload_q, payload_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               advance;

  letc_core_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req          (bus.i_req_valid),
    .i_advance      (advance),
    .o_grant_onehot (pick_onehot),
    .o_grant_idx    (pick_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      payload_q   <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    payload_d        = payload_q;
    grant_idx_d      = grant_idx_q;
    advance          = 1'b0;
    bus.o_req_ready  = '0;
    bus.o_rsp_valid  = '0;
    bus.o_rsp_rdata  = '0;
    bus.o_cache_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.i_req_valid) begin
          advance         = 1'b1;
          bus.o_req_ready = pick_onehot;
          payload_d       = bus.i_req[pick_idx];
          grant_idx_d     = pick_idx;
          state_d         = REQ;
        end
      end
      REQ: begin
        bus.o_cache_valid = 1'b1;
        if (bus.i_cache_ready) state_d = WAIT;
      end
      WAIT: begin
        // Arbitration resumes only in the cycle after the response.
        bus.o_rsp_valid[grant_idx_q] = bus.i_cache_rsp_valid;
        bus.o_rsp_rdata              = bus.i_cache_rsp_rdata;
        if (bus.i_cache_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_cache_req = payload_q;
  assign o_busy          = (state_q != IDLE);
  assign o_grant_idx     = grant_idx_q;
  assign o_state         = state_q;

`ifdef SIMULATION
  a_ready_onehot0: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(bus.o_req_ready));
  a_req_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (bus.o_cache_valid && !bus.i_cache_ready) |=> $stable(bus.o_cache_req));
  a_rsp_in_wait: assert property (@(posedge i_clk) disable iff (i_rst)
    bus.i_cache_rsp_valid |-> (state_q == WAIT));
`endif

endmodule

// File: tb/tb_letc_core_cache_arbiter.sv
// Directed bench for letc_core_cache_arbiter; expected cache requests and
// responses are queued by the stimulus and checked by a negedge monitor.
module tb_letc_core_cache_arbiter;
  import letc_core_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 1;
  localparam int PW      = $bits(cache_req_t);
  localparam int CW      = IDX_W + PW;
  localparam int RW      = 1 + NUM_REQ + DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             o_busy;
  logic [IDX_W-1:0] o_grant_idx;
  arb_state_e       o_state;

  int tests = 0;
  int fails = 0;

  logic [CW-1:0] exp_creq_q[$];
  logic [RW-1:0] exp_rsp_q[$];
  logic [CW-1:0] creq_e;
  logic [RW-1:0] rsp_e;

  letc_core_cache_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  letc_core_cache_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(32), .DATA_W(DATA_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_grant_idx (o_grant_idx),
    .o_state     (o_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  function automatic cache_req_t mk(input logic [31:0] a, input logic w,
                                    input logic [31:0] d, input cache_size_e s);
    cache_req_t r;
    r.addr  = a;
    r.wen   = w;
    r.wdata = d;
    r.size  = s;
    return r;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int g);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic push_creq(input int g, input cache_req_t r);
    exp_creq_q.push_back({IDX_W'(g), r});
  endtask

  task automatic push_rsp(input logic chk_data, input logic [NUM_REQ-1:0] v,
                          input logic [DATA_W-1:0] d);
    exp_rsp_q.push_back({chk_data, v, d});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_cache_valid && bus.i_cache_ready) begin
        if (exp_creq_q.size() == 0) begin
          check("cache_req_unexpected", 128'(bus.o_cache_req), 128'(0));
        end else begin
          creq_e = exp_creq_q.pop_front();
          check("cache_req", 128'(bus.o_cache_req), 128'(creq_e[PW-1:0]));
          check("cache_grant_idx", 128'(o_grant_idx), 128'(creq_e[PW +: IDX_W]));
        end
      end
      if (bus.o_rsp_valid != '0) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected", 128'(bus.o_rsp_valid), 128'(0));
        end else begin
          rsp_e = exp_rsp_q.pop_front();
          check("rsp_valid", 128'(bus.o_rsp_valid), 128'(rsp_e[DATA_W +: NUM_REQ]));
          if (rsp_e[RW-1]) check("rsp_rdata", 128'(bus.o_rsp_rdata), 128'(rsp_e[DATA_W-1:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int         exp_grant [4];
  cache_req_t r0, r1, r;

  initial begin
`ifdef LETC_CORE_CACHE_ARB_FIXED_PRIO_EN
    exp_grant = '{0, 0, 0, 0};
`else
    exp_grant = '{0, 1, 0, 1};
`endif
    rst                   = 1'b1;
    bus.i_req_valid       = '0;
    bus.i_req             = '0;
    bus.i_cache_ready     = 1'b0;
    bus.i_cache_rsp_valid = 1'b0;
    bus.i_cache_rsp_rdata = '0;

    // Reset state
    at_neg();
    check("rst_req_ready", 128'(bus.o_req_ready), 128'(0));
    check("rst_rsp_valid", 128'(bus.o_rsp_valid), 128'(0));
    check("rst_cache_valid", 128'(bus.o_cache_valid), 128'(0));
    check("rst_cache_req", 128'(bus.o_cache_req), 128'(0));
    check("rst_busy", 128'(o_busy), 128'(0));
    check("rst_grant_idx", 128'(o_grant_idx), 128'(0));
    cyc();
    cyc();
    rst = 1'b0;

    // Both requesters valid for four back-to-back transactions
    r0 = mk(32'h0000_0100, 1'b0, 32'h0, WORD);
    r1 = mk(32'h0000_0200, 1'b0, 32'h0, WORD);
    bus.i_req[0]      = r0;
    bus.i_req[1]      = r1;
    bus.i_req_valid   = 2'b11;
    bus.i_cache_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      push_creq(exp_grant[t], (exp_grant[t] == 1) ? r1 : r0);
      push_rsp(1'b1, onehot(exp_grant[t]), 32'hA0 + 32'(t));
      at_neg();
      check("t2_grant_ready", 128'(bus.o_req_ready), 128'(onehot(exp_grant[t])));
      cyc();
      cyc();
      bus.i_cache_rsp_valid = 1'b1;
      bus.i_cache_rsp_rdata = 32'hA0 + 32'(t);
      cyc();
      bus.i_cache_rsp_valid = 1'b0;
    end
    bus.i_req_valid   = '0;
    bus.i_cache_ready = 1'b0;

    // Single read from requester 0 with cycle-level timing
    r = mk(32'h0000_1000, 1'b0, 32'h0, WORD);
    bus.i_req[0]    = r;
    bus.i_req_valid = 2'b01;
    push_creq(0, r);
    push_rsp(1'b1, 2'b01, 32'hDEAD_BEEF);
    at_neg();
    check("t1_ready_c0", 128'(bus.o_req_ready), 128'(2'b01));
    check("t1_busy_c0", 128'(o_busy), 128'(0));
    cyc();
    bus.i_req_valid   = '0;
    bus.i_cache_ready = 1'b1;
    at_neg();
    check("t1_cache_valid_c1", 128'(bus.o_cache_valid), 128'(1));
    check("t1_busy_c1", 128'(o_busy), 128'(1));
    cyc();
    bus.i_cache_ready = 1'b0;
    at_neg();
    check("t1_no_rsp_c2", 128'(bus.o_rsp_valid), 128'(0));
    cyc();
    bus.i_cache_rsp_valid = 1'b1;
    bus.i_cache_rsp_rdata = 32'hDEAD_BEEF;
    at_neg();
    check("t1_busy_c3", 128'(o_busy), 128'(1));
    cyc();
    bus.i_cache_rsp_valid = 1'b0;
    bus.i_cache_rsp_rdata = '0;
    at_neg();
    check("t1_busy_c4", 128'(o_busy), 128'(0));

    // Cache stalls ready for five cycles
    cyc();
    r = mk(32'h0000_3000, 1'b0, 32'h0, HALF);
    bus.i_req[0]    = r;
    bus.i_req_valid = 2'b01;
    push_creq(0, r);
    push_rsp(1'b1, 2'b01, 32'h3333_3333);
    at_neg();
    check("t3_ready", 128'(bus.o_req_ready), 128'(2'b01));
    cyc();
    bus.i_req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("t3_cache_valid_hold", 128'(bus.o_cache_valid), 128'(1));
      check("t3_cache_req_stable", 128'(bus.o_cache_req), 128'(r));
      cyc();
    end
    bus.i_cache_ready = 1'b1;
    at_neg();
    cyc();
    bus.i_cache_ready     = 1'b0;
    bus.i_cache_rsp_valid = 1'b1;
    bus.i_cache_rsp_rdata = 32'h3333_3333;
    at_neg();
    check("t3_wait_state", 128'(o_state), 128'(WAIT));
    check("t3_wait_no_cache_valid", 128'(bus.o_cache_valid), 128'(0));
    cyc();
    bus.i_cache_rsp_valid = 1'b0;
    at_neg();
    check("t3_busy_done", 128'(o_busy), 128'(0));

    // Write from requester 1
    cyc();
    r = mk(32'h0000_4000, 1'b1, 32'h1234_5678, WORD);
    bus.i_req[1]    = r;
    bus.i_req_valid = 2'b10;
    push_creq(1, r);
    push_rsp(1'b0, 2'b10, 32'h0);
    at_neg();
    check("t4_ready", 128'(bus.o_req_ready), 128'(2'b10));
    cyc();
    bus.i_req_valid   = '0;
    bus.i_cache_ready = 1'b1;
    cyc();
    bus.i_cache_ready     = 1'b0;
    bus.i_cache_rsp_valid = 1'b1;
    bus.i_cache_rsp_rdata = 32'hFFFF_FFFF;
    cyc();
    bus.i_cache_rsp_valid = 1'b0;
    bus.i_cache_rsp_rdata = '0;

    // Spurious responses in IDLE and REQ, then reset mid-WAIT
    bus.i_cache_rsp_valid = 1'b1;
    bus.i_cache_rsp_rdata = 32'h5555_5555;
    at_neg();
    check("t5_spurious_idle_rsp", 128'(bus.o_rsp_valid), 128'(0));
    check("t5_spurious_idle_busy", 128'(o_busy), 128'(0));
    cyc();
    bus.i_cache_rsp_valid = 1'b0;
    r = mk(32'h0000_5000, 1'b0, 32'h0, BYTE);
    bus.i_req[1]    = r;
    bus.i_req_valid = 2'b10;
    push_creq(1, r);
    at_neg();
    check("t5_ready", 128'(bus.o_req_ready), 128'(2'b10));
    cyc();
    bus.i_req_valid       = '0;
    bus.i_cache_rsp_valid = 1'b1;
    at_neg();
    check("t5_spurious_req_rsp", 128'(bus.o_rsp_valid), 128'(0));
    check("t5_spurious_req_state", 128'(o_state), 128'(REQ));
    cyc();
    bus.i_cache_rsp_valid = 1'b0;
    bus.i_cache_rsp_rdata = '0;
    bus.i_cache_ready     = 1'b1;
    cyc();
    bus.i_cache_ready = 1'b0;
    at_neg();
    check("t5_grant_idx_wait", 128'(o_grant_idx), 128'(1));
    check("t5_state_wait", 128'(o_state), 128'(WAIT));
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_req_ready", 128'(bus.o_req_ready), 128'(0));
    check("t5_rst_rsp_valid", 128'(bus.o_rsp_valid), 128'(0));
    check("t5_rst_rsp_rdata", 128'(bus.o_rsp_rdata), 128'(0));
    check("t5_rst_cache_valid", 128'(bus.o_cache_valid), 128'(0));
    check("t5_rst_cache_req", 128'(bus.o_cache_req), 128'(0));
    check("t5_rst_busy", 128'(o_busy), 128'(0));
    check("t5_rst_grant_idx", 128'(o_grant_idx), 128'(0));
    check("t5_rst_state", 128'(o_state), 128'(IDLE));
    cyc();
    rst = 1'b0;

    // Response cycle coincides with requester 0 raising valid
    r1 = mk(32'h0000_6000, 1'b0, 32'h0, WORD);
    bus.i_req[1]    = r1;
    bus.i_req_valid = 2'b10;
    push_creq(1, r1);
    push_rsp(1'b1, 2'b10, 32'h6666_6666);
    at_neg();
    check("t6_ready_r1", 128'(bus.o_req_ready), 128'(2'b10));
    cyc();
    bus.i_req_valid   = '0;
    bus.i_cache_ready = 1'b1;
    cyc();
    bus.i_cache_ready     = 1'b0;
    bus.i_cache_rsp_valid = 1'b1;
    bus.i_cache_rsp_rdata = 32'h6666_6666;
    r0 = mk(32'h0000_7000, 1'b0, 32'h0, WORD);
    bus.i_req[0]    = r0;
    bus.i_req_valid = 2'b01;
    push_creq(0, r0);
    push_rsp(1'b1, 2'b01, 32'h7777_7777);
    at_neg();
    check("t6_no_ready_in_rsp_cycle", 128'(bus.o_req_ready), 128'(0));
    cyc();
    bus.i_cache_rsp_valid = 1'b0;
    at_neg();
    check("t6_ready_next_cycle", 128'(bus.o_req_ready), 128'(2'b01));
    cyc();
    bus.i_req_valid   = '0;
    bus.i_cache_ready = 1'b1;
    cyc();
    bus.i_cache_ready     = 1'b0;
    bus.i_cache_rsp_valid = 1'b1;
    bus.i_cache_rsp_rdata = 32'h7777_7777;
    cyc();
    bus.i_cache_rsp_valid = 1'b0;
    bus.i_cache_rsp_rdata = '0;

    // Drain and final report
    repeat (3) cyc();
    check("creq_queue_empty", 128'(exp_creq_q.size()), 128'(0));
    check("rsp_queue_empty", 128'(exp_rsp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
